// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 Hz timing constants and helpers for the VGA raster and
// the CA renderer's padding arithmetic.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int unsigned H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  typedef logic [POS_W-1:0] pos_t;

  function automatic logic sync_level(input logic active, input bit neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the timing generator to the CA renderer.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  pos_t       hpos;
  pos_t       vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output hpos, vpos, hsync, vsync, display_on,
    output line_start, frame_start, frame_count
  );

  modport slave (
    input hpos, vpos, hsync, vsync, display_on,
    input line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-MOD counter that resets to MOD-1 so the first enabled edge lands on 0.
module wrap_counter #(
  parameter int unsigned MOD = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_comb begin
    wrap     = en && (cnt == LAST);
    cnt_next = cnt;
    if (en) cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= LAST;
    else        cnt <= cnt_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing: h/v counters plus registered sync, display and strobe
// decode aligned to the same pixel as hpos/vpos.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          SYNC_NEG  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_DISP   = pos_t'(H_DISPLAY);
  localparam pos_t HS_START = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam pos_t V_DISP   = pos_t'(V_DISPLAY);
  localparam pos_t VS_START = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_END   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC);

  pos_t       h_cnt, h_next;
  pos_t       v_cnt, v_next;
  logic       h_wrap, v_wrap, v_en;
  logic       hs_act, vs_act, de_next;
  logic       hsync_q, vsync_q, de_q, ls_q, fs_q;
  logic [7:0] fc_q;

  assign v_en = ena & h_wrap;

  wrap_counter #(.MOD(H_TOT), .W(POS_W)) u_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ena),
    .cnt      (h_cnt),
    .cnt_next (h_next),
    .wrap     (h_wrap)
  );

  wrap_counter #(.MOD(V_TOT), .W(POS_W)) u_v (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (v_en),
    .cnt      (v_cnt),
    .cnt_next (v_next),
    .wrap     (v_wrap)
  );

  // Decode from next-state counts so the registered outputs line up with hpos/vpos.
  always_comb begin
    hs_act  = (h_next >= HS_START) && (h_next < HS_END);
    vs_act  = (v_next >= VS_START) && (v_next < VS_END);
    de_next = (h_next < H_DISP) && (v_next < V_DISP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= sync_level(1'b0, SYNC_NEG);
      vsync_q <= sync_level(1'b0, SYNC_NEG);
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '1;
    end else begin
      hsync_q <= sync_level(hs_act, SYNC_NEG);
      vsync_q <= sync_level(vs_act, SYNC_NEG);
      de_q    <= de_next;
      ls_q    <= h_wrap;
      fs_q    <= v_wrap;
      if (v_wrap) fc_q <= fc_q + 8'd1;
    end
  end

  assign vga.hpos        = h_cnt;
  assign vga.vpos        = v_cnt;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-ena bench for vga_timing_gen: a default 640x480 instance and a
// tiny positive-sync instance, both checked every cycle against a raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk;
  logic rst_n;
  logic ena;

  int unsigned checks = 0;
  int unsigned passes = 0;

  longint unsigned adv = 0;
  bit              last_en = 1'b0;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();

  vga_timing_gen #(.SYNC_NEG(1'b1)) u_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .vga   (d_if)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_NEG(1'b0)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .vga   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t d_obs, s_obs;
  assign d_obs = '{d_if.hpos, d_if.vpos, d_if.hsync, d_if.vsync, d_if.display_on,
                   d_if.line_start, d_if.frame_start, d_if.frame_count};
  assign s_obs = '{s_if.hpos, s_if.vpos, s_if.hsync, s_if.vsync, s_if.display_on,
                   s_if.line_start, s_if.frame_start, s_if.frame_count};

  // Raster as a function of how many enabled edges have elapsed since reset.
  function automatic obs_t model(input longint unsigned n, input bit en_last,
                                 input int unsigned hd, input int unsigned hf,
                                 input int unsigned hsw, input int unsigned hb,
                                 input int unsigned vd, input int unsigned vf,
                                 input int unsigned vsw, input int unsigned vb,
                                 input bit neg);
    obs_t o;
    longint unsigned ht, vt, k, h, v;
    bit hs_act, vs_act;
    ht = longint'(hd + hf + hsw + hb);
    vt = longint'(vd + vf + vsw + vb);
    if (n == 0) begin
      o.h  = 10'(ht - 1);
      o.v  = 10'(vt - 1);
      o.hs = neg;
      o.vs = neg;
      o.de = 1'b0;
      o.ls = 1'b0;
      o.fs = 1'b0;
      o.fc = 8'hFF;
    end else begin
      k = n - 1;
      h = k % ht;
      v = (k / ht) % vt;
      hs_act = (h >= longint'(hd + hf)) && (h < longint'(hd + hf + hsw));
      vs_act = (v >= longint'(vd + vf)) && (v < longint'(vd + vf + vsw));
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.hs = hs_act ? ~neg : neg;
      o.vs = vs_act ? ~neg : neg;
      o.de = (h < longint'(hd)) && (v < longint'(vd));
      o.ls = en_last && (h == 0);
      o.fs = en_last && (h == 0) && (v == 0);
      o.fc = 8'((k / (ht * vt)) % 256);
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv     = 0;
      last_en = 1'b0;
    end else begin
      last_en = ena;
      if (ena) adv++;
    end
  end

  always @(negedge clk) begin
    obs_t de, se;
    de = model(adv, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
    se = model(adv, last_en, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0);
    chk("dflt_cycle", 32'(d_obs), 32'(de));
    chk("small_cycle", 32'(s_obs), 32'(se));
    if (last_en) begin
      if (adv == 656) chk("dflt_hs_655", 32'(d_if.hsync), 32'd1);
      if (adv == 657) chk("dflt_hs_656", 32'(d_if.hsync), 32'd0);
      if (adv == 752) chk("dflt_hs_751", 32'(d_if.hsync), 32'd0);
      if (adv == 753) chk("dflt_hs_752", 32'(d_if.hsync), 32'd1);
      if (adv == 641) chk("dflt_de_640", 32'(d_if.display_on), 32'd0);
      if (adv == 801) begin
        chk("dflt_line2_v", 32'(d_if.vpos), 32'd1);
        chk("dflt_line2_ls", 32'(d_if.line_start), 32'd1);
      end
      if (adv == 76) chk("small_vs_line5", 32'(s_if.vsync), 32'd1);
      if (adv == 121) chk("small_fc_1", 32'(s_if.frame_count), 32'd1);
      if (adv == 30721) begin
        chk("small_fc_wrap", 32'(s_if.frame_count), 32'd0);
        chk("small_fs_wrap", 32'(s_if.frame_start), 32'd1);
      end
    end
  end

  task automatic first_edge_pins(input string tag);
    chk({tag, "_h"},  32'(d_if.hpos), 32'd0);
    chk({tag, "_v"},  32'(d_if.vpos), 32'd0);
    chk({tag, "_de"}, 32'(d_if.display_on), 32'd1);
    chk({tag, "_fs"}, 32'(d_if.frame_start), 32'd1);
    chk({tag, "_ls"}, 32'(d_if.line_start), 32'd1);
    chk({tag, "_fc"}, 32'(d_if.frame_count), 32'd0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    ena   = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    ena = 1'b1;
    @(posedge clk);
    #1 first_edge_pins("first");

    repeat (5) @(posedge clk);
    #2 ena = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("frz_h", 32'(d_if.hpos), 32'd5);
    chk("frz_ls", 32'(d_if.line_start), 32'd0);
    chk("frz_fs", 32'(d_if.frame_start), 32'd0);
    #1 ena = 1'b1;
    @(posedge clk);
    #1 chk("resume_h", 32'(d_if.hpos), 32'd6);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2 ena = ($urandom_range(7, 0) != 0);
    end

    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk);
      #1 if (d_if.hpos == 10'd300) hit = 1'b1;
    end
    chk("reach_h300", 32'(hit), 32'd1);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_h", 32'(d_if.hpos), 32'd799);
    chk("rst_v", 32'(d_if.vpos), 32'd524);
    chk("rst_hs", 32'(d_if.hsync), 32'd1);
    chk("rst_vs", 32'(d_if.vsync), 32'd1);
    chk("rst_de", 32'(d_if.display_on), 32'd0);
    chk("rst_ls", 32'(d_if.line_start), 32'd0);
    chk("rst_fs", 32'(d_if.frame_start), 32'd0);
    chk("rst_fc", 32'(d_if.frame_count), 32'hFF);
    chk("rst_small_h", 32'(s_if.hpos), 32'd14);
    chk("rst_small_hs", 32'(s_if.hsync), 32'd0);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ena = 1'b1;
    @(posedge clk);
    #1 first_edge_pins("restart");

    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      #2 ena = ($urandom_range(15, 0) != 0);
    end
    chk("reached_wrap", 32'(adv > 30721), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
